// File: rtl/reg_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_ctrl_if
// Description : Bundle between the register-dump sequencer, the CU/datapath
//               override inputs, the register-file T port and the dump
//               stream consumer.
//               master : the sequencer (drives overrides, t_addr, stream)
//               slave  : the environment (CU, register file, consumer)
// Ports       : dump_req, t_data, dout_ready         (slave -> master)
//               cu_halt, t_addr, t_sel, fs, y_sel,
//               d_en, hilo_ld, dout, dout_idx,
//               dout_valid, mem_out, busy            (master -> slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_dump_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              dump_req;
    logic [DATA_W-1:0] t_data;
    logic              dout_ready;
    logic              cu_halt;
    logic [4:0]        t_addr;
    logic              t_sel;
    logic [4:0]        fs;
    logic [2:0]        y_sel;
    logic              d_en;
    logic              hilo_ld;
    logic [DATA_W-1:0] dout;
    logic [4:0]        dout_idx;
    logic              dout_valid;
    logic              mem_out;
    logic              busy;

    modport master (
        input  dump_req, t_data, dout_ready,
        output cu_halt, t_addr, t_sel, fs, y_sel, d_en, hilo_ld,
               dout, dout_idx, dout_valid, mem_out, busy
    );

    modport slave (
        output dump_req, t_data, dout_ready,
        input  cu_halt, t_addr, t_sel, fs, y_sel, d_en, hilo_ld,
               dout, dout_idx, dout_valid, mem_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_ctrl
// Description : Register-dump sequencer. On dump_req it halts the CU, drives
//               the control-word overrides that route the register-file T
//               port onto the Y bus, walks t_addr 0..NUM_REGS-1, streams each
//               value over a valid/ready port and finally pulses mem_out.
// Ports       : sys_clk  - system clock (rising edge)
//               sys_rst  - asynchronous active-high reset
//               bus      - reg_dump_ctrl_if.master (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32
) (
    input  wire               sys_clk,
    input  wire               sys_rst,
    reg_dump_ctrl_if.master   bus
);
    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    // Override values that steer the T port through the ALU onto Y.
    localparam logic [4:0] FS_PASS_T = 5'h01;
    localparam logic [2:0] Y_SEL_ALU = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_HOLD   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            state_q;
    logic [4:0]        idx_q;
    logic              cu_halt_q;
    logic              t_sel_q;
    logic [4:0]        fs_q;
    logic [2:0]        y_sel_q;
    logic [DATA_W-1:0] dout_q;
    logic [4:0]        dout_idx_q;
    logic              dout_valid_q;
    logic              mem_out_q;
    logic              busy_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 5'd0;
            cu_halt_q    <= 1'b0;
            t_sel_q      <= 1'b0;
            fs_q         <= 5'd0;
            y_sel_q      <= 3'd0;
            dout_q       <= '0;
            dout_idx_q   <= 5'd0;
            dout_valid_q <= 1'b0;
            mem_out_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.dump_req) begin
                        state_q   <= S_DRIVE;
                        idx_q     <= 5'd0;
                        cu_halt_q <= 1'b1;
                        t_sel_q   <= 1'b1;
                        fs_q      <= FS_PASS_T;
                        y_sel_q   <= Y_SEL_ALU;
                        busy_q    <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    // Register file has had the whole DRIVE cycle to settle.
                    dout_q       <= bus.t_data;
                    dout_idx_q   <= idx_q;
                    dout_valid_q <= 1'b1;
                    state_q      <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.dout_ready) begin
                        dout_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q   <= S_FINISH;
                            mem_out_q <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 5'd1;
                            state_q <= S_DRIVE;
                        end
                    end
                end
                S_FINISH: begin
                    // Return every output to zero so IDLE is fully quiet.
                    state_q    <= S_IDLE;
                    idx_q      <= 5'd0;
                    mem_out_q  <= 1'b0;
                    cu_halt_q  <= 1'b0;
                    t_sel_q    <= 1'b0;
                    fs_q       <= 5'd0;
                    y_sel_q    <= 3'd0;
                    dout_q     <= '0;
                    dout_idx_q <= 5'd0;
                    busy_q     <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cu_halt    = cu_halt_q;
    assign bus.t_addr     = idx_q;
    assign bus.t_sel      = t_sel_q;
    assign bus.fs         = fs_q;
    assign bus.y_sel      = y_sel_q;
    // The dump must never write the register file or HI/LO.
    assign bus.d_en       = 1'b0;
    assign bus.hilo_ld    = 1'b0;
    assign bus.dout       = dout_q;
    assign bus.dout_idx   = dout_idx_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.mem_out    = mem_out_q;
    assign bus.busy       = busy_q;
endmodule
`default_nettype wire
